// File: rtl/dp_seq_pkg.sv
// Shared types for the datapath vector sequencer: FSM state encoding and the stored test-vector record.
// Record field widths are fixed here; the sequencer's DW/RW parameters default to them and must match.
package dp_seq_pkg;

  localparam int VEC_DW = 8;
  localparam int VEC_RW = 16;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT,
    CHECK,
    DONE
  } state_t;

  typedef struct packed {
    logic signed [VEC_DW-1:0] a;
    logic signed [VEC_DW-1:0] b;
    logic signed [VEC_RW-1:0] exp;
  } vec_t;

endpackage

// File: rtl/dp_vector_sequencer_if.sv
// Operand/result link between the sequencer (master: sources a, b, sinks x) and the datapath under test (slave).
interface dp_vector_sequencer_if #(
  parameter int DW = 8,
  parameter int RW = 16
);

  logic signed [DW-1:0] op_a;
  logic signed [DW-1:0] op_b;
  logic signed [RW-1:0] res_in;

  modport master (output op_a, output op_b, input res_in);
  modport slave  (input op_a, input op_b, output res_in);

endinterface

// File: rtl/dp_vec_mem.sv
// Test-vector store: DEPTH records, synchronous write, asynchronous read.
module dp_vec_mem
  import dp_seq_pkg::*;
#(
  parameter int  DEPTH = 16,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  vec_t          wdata,
  input  logic [AW-1:0] raddr,
  output vec_t          rdata
);

  vec_t mem [DEPTH];

  // NOTE: the array has no reset; contents are only meaningful after being loaded, and a reset port would block RAM inference.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/dp_vector_sequencer.sv
// Vector sequencer: issues stored {a, b, exp} records to a registered datapath, checks each result, counts mismatches.
// Define DP_SEQ_STOP_ON_FAIL_EN to end a run at its first mismatching vector; default runs every vector.
module dp_vector_sequencer
  import dp_seq_pkg::*;
#(
  parameter int  DW    = VEC_DW,
  parameter int  RW    = VEC_RW,
  parameter int  DEPTH = 16,
  parameter int  LAT   = 1,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load_we,
  input  logic [AW-1:0]        load_addr,
  input  logic signed [DW-1:0] load_a,
  input  logic signed [DW-1:0] load_b,
  input  logic signed [RW-1:0] load_exp,
  input  logic [AW:0]          vec_count,
  input  logic                 start,
  dp_vector_sequencer_if.master dp,
  output logic                 busy,
  output logic                 done,
  output logic [AW-1:0]        idx,
  output logic [AW:0]          mismatch_cnt,
  output logic                 pass
);

  localparam int               CW      = AW + 1;
  localparam int               WW      = (LAT > 1) ? $clog2(LAT) : 1;
  localparam logic [CW-1:0]    DEPTH_C = CW'(DEPTH);

  state_t              state;
  logic [CW-1:0]       count_q;
  logic [WW-1:0]       wait_cnt;
  logic signed [RW-1:0] exp_q;

  vec_t                wr_vec;
  vec_t                rd_vec;
  vec_t                issue_vec;
  logic [AW-1:0]       rd_addr;
  logic                accept_load;
  logic                is_last;
  logic                is_miss;
  logic                check_end;
  logic [CW-1:0]       mis_next;

  assign accept_load = load_we && (state == IDLE);
  assign wr_vec      = '{a: load_a, b: load_b, exp: load_exp};

  // Operands are loaded on entry to ISSUE, so read the entry about to be issued: 0 from IDLE, idx+1 from CHECK.
  assign rd_addr = (state == CHECK) ? idx + AW'(1) : '0;

  dp_vec_mem #(.DEPTH(DEPTH)) u_mem (
    .clk   (clk),
    .we    (accept_load),
    .waddr (load_addr),
    .wdata (wr_vec),
    .raddr (rd_addr),
    .rdata (rd_vec)
  );

  // A write landing in the same cycle as start must be seen by the first issue.
  assign issue_vec = (accept_load && (load_addr == rd_addr)) ? wr_vec : rd_vec;

  assign is_last  = ({1'b0, idx} + CW'(1)) == count_q;
  assign is_miss  = dp.res_in != exp_q;
  assign mis_next = (is_miss && (mismatch_cnt != '1)) ? mismatch_cnt + CW'(1) : mismatch_cnt;

`ifdef DP_SEQ_STOP_ON_FAIL_EN
  assign check_end = is_last || is_miss;
`else
  assign check_end = is_last;
`endif

  // NOTE: every register here uses non-blocking assignment so all state updates see the pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= IDLE;
      count_q      <= '0;
      wait_cnt     <= '0;
      exp_q        <= '0;
      dp.op_a      <= '0;
      dp.op_b      <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      idx          <= '0;
      mismatch_cnt <= '0;
      pass         <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            idx          <= '0;
            mismatch_cnt <= '0;
            pass         <= 1'b0;
            count_q      <= (vec_count > DEPTH_C) ? DEPTH_C : vec_count;
            if (vec_count == '0) begin
              state <= DONE;
              done  <= 1'b1;
              pass  <= 1'b1;
            end else begin
              state   <= ISSUE;
              busy    <= 1'b1;
              dp.op_a <= issue_vec.a;
              dp.op_b <= issue_vec.b;
              exp_q   <= issue_vec.exp;
            end
          end
        end

        ISSUE: begin
          if (LAT > 1) begin
            state    <= WAIT;
            wait_cnt <= WW'(LAT - 2);
          end else begin
            state <= CHECK;
          end
        end

        WAIT: begin
          if (wait_cnt == '0) begin
            state <= CHECK;
          end else begin
            wait_cnt <= wait_cnt - WW'(1);
          end
        end

        CHECK: begin
          mismatch_cnt <= mis_next;
          if (check_end) begin
            state <= DONE;
            done  <= 1'b1;
            busy  <= 1'b0;
            pass  <= (mis_next == '0);
          end else begin
            state   <= ISSUE;
            idx     <= idx + AW'(1);
            dp.op_a <= issue_vec.a;
            dp.op_b <= issue_vec.b;
            exp_q   <= issue_vec.exp;
          end
        end

        DONE: begin
          state <= IDLE;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dp_vector_sequencer.sv
// Directed bench for dp_vector_sequencer: an adder datapath behind a LAT=1 instance and a LAT=3 instance.
module tb_dp_vector_sequencer;

  localparam int DW    = 8;
  localparam int RW    = 16;
  localparam int DEPTH = 16;
  localparam int AW    = 4;
  localparam int CW    = 5;

  logic                 clk = 1'b0;
  logic                 rst = 1'b0;
  logic                 load_we = 1'b0;
  logic [AW-1:0]        load_addr = '0;
  logic signed [DW-1:0] load_a = '0;
  logic signed [DW-1:0] load_b = '0;
  logic signed [RW-1:0] load_exp = '0;
  logic [CW-1:0]        vec_count = '0;
  logic                 start = 1'b0;

  logic          busy1, done1, pass1, busy3, done3, pass3;
  logic [AW-1:0] idx1, idx3;
  logic [CW-1:0] mis1, mis3;

  int compared   = 0;
  int mismatched = 0;

  dp_vector_sequencer_if #(.DW(DW), .RW(RW)) dp1 ();
  dp_vector_sequencer_if #(.DW(DW), .RW(RW)) dp3 ();

  always #5 clk = ~clk;

  // Datapath models: x = sext(a) + sext(b), registered with 1 and 3 stages.
  logic signed [RW-1:0] p3_0, p3_1;
  always @(posedge clk) begin
    dp1.res_in <= {{(RW-DW){dp1.op_a[DW-1]}}, dp1.op_a} + {{(RW-DW){dp1.op_b[DW-1]}}, dp1.op_b};
    p3_0       <= {{(RW-DW){dp3.op_a[DW-1]}}, dp3.op_a} + {{(RW-DW){dp3.op_b[DW-1]}}, dp3.op_b};
    p3_1       <= p3_0;
    dp3.res_in <= p3_1;
  end

  dp_vector_sequencer #(.DW(DW), .RW(RW), .DEPTH(DEPTH), .LAT(1)) u_dut1 (
    .clk(clk), .rst(rst), .load_we(load_we), .load_addr(load_addr), .load_a(load_a), .load_b(load_b),
    .load_exp(load_exp), .vec_count(vec_count), .start(start), .dp(dp1),
    .busy(busy1), .done(done1), .idx(idx1), .mismatch_cnt(mis1), .pass(pass1)
  );

  dp_vector_sequencer #(.DW(DW), .RW(RW), .DEPTH(DEPTH), .LAT(3)) u_dut3 (
    .clk(clk), .rst(rst), .load_we(load_we), .load_addr(load_addr), .load_a(load_a), .load_b(load_b),
    .load_exp(load_exp), .vec_count(vec_count), .start(start), .dp(dp3),
    .busy(busy3), .done(done3), .idx(idx3), .mismatch_cnt(mis3), .pass(pass3)
  );

  task automatic load_vec(input int addr, input int a, input int b, input int e);
    @(negedge clk);
    load_we = 1'b1; load_addr = AW'(addr); load_a = DW'(a); load_b = DW'(b); load_exp = RW'(e);
    @(negedge clk);
    load_we = 1'b0;
  endtask

  // Returns at the negedge one cycle after start was sampled (cycle 1 of the run).
  task automatic start_run(input int n, output int cyc);
    @(negedge clk);
    vec_count = CW'(n); start = 1'b1;
    @(negedge clk);
    start = 1'b0; cyc = 1;
  endtask

  task automatic wait_done(input bit on3, inout int cyc);
    while (!(on3 ? done3 : done1) && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    if (!(on3 ? done3 : done1)) begin
      compared++; mismatched++;
      $display("FAIL done_timeout: no done pulse after %0d cycles", cyc);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (2) @(negedge clk);
    compared++; if (dp1.op_a !== 8'h00) begin mismatched++; $display("FAIL rst_op_a: got %0d expected 0", dp1.op_a); end
    compared++; if (dp1.op_b !== 8'h00) begin mismatched++; $display("FAIL rst_op_b: got %0d expected 0", dp1.op_b); end
    compared++; if (busy1 !== 1'b0) begin mismatched++; $display("FAIL rst_busy: got %b expected 0", busy1); end
    compared++; if (done1 !== 1'b0) begin mismatched++; $display("FAIL rst_done: got %b expected 0", done1); end
    compared++; if (pass1 !== 1'b0) begin mismatched++; $display("FAIL rst_pass: got %b expected 0", pass1); end
    compared++; if (idx1 !== 4'd0) begin mismatched++; $display("FAIL rst_idx: got %0d expected 0", idx1); end
    compared++; if (mis1 !== 5'd0) begin mismatched++; $display("FAIL rst_mis: got %0d expected 0", mis1); end
    rst = 1'b1;
  endtask

  task automatic test_zero_count();
    int cyc;
    start_run(0, cyc);
    compared++; if (done1 !== 1'b1) begin mismatched++; $display("FAIL zero_done: got %b expected 1", done1); end
    compared++; if (pass1 !== 1'b1) begin mismatched++; $display("FAIL zero_pass: got %b expected 1", pass1); end
    compared++; if (busy1 !== 1'b0) begin mismatched++; $display("FAIL zero_busy: got %b expected 0", busy1); end
    compared++; if (dp1.op_a !== 8'h00 || dp1.op_b !== 8'h00) begin
      mismatched++; $display("FAIL zero_ops: got %0d,%0d expected 0,0", dp1.op_a, dp1.op_b);
    end
    @(negedge clk);
    compared++; if (done1 !== 1'b0) begin mismatched++; $display("FAIL zero_done_pulse: got %b expected 0", done1); end
    compared++; if (pass1 !== 1'b1) begin mismatched++; $display("FAIL zero_pass_hold: got %b expected 1", pass1); end
  endtask

  task automatic test_basic();
    int cyc;
    load_vec(0, 3, 4, 7);
    load_vec(1, -2, 5, 3);
    load_vec(2, 127, 1, 128);
    start_run(3, cyc);
    compared++; if (dp1.op_a !== 8'd3 || dp1.op_b !== 8'd4) begin
      mismatched++; $display("FAIL basic_ops0: got %0d,%0d expected 3,4", dp1.op_a, dp1.op_b);
    end
    compared++; if (busy1 !== 1'b1) begin mismatched++; $display("FAIL basic_busy: got %b expected 1", busy1); end
    repeat (2) begin @(negedge clk); cyc++; end
    compared++; if (dp1.op_a !== 8'hFE || dp1.op_b !== 8'd5 || idx1 !== 4'd1) begin
      mismatched++; $display("FAIL basic_ops1: got %0d,%0d idx %0d expected -2,5 idx 1", dp1.op_a, dp1.op_b, idx1);
    end
    wait_done(1'b0, cyc);
    compared++; if (cyc !== 7) begin mismatched++; $display("FAIL basic_cycles: got %0d expected 7", cyc); end
    compared++; if (pass1 !== 1'b1) begin mismatched++; $display("FAIL basic_pass: got %b expected 1", pass1); end
    compared++; if (mis1 !== 5'd0) begin mismatched++; $display("FAIL basic_mis: got %0d expected 0", mis1); end
    compared++; if (idx1 !== 4'd2) begin mismatched++; $display("FAIL basic_idx: got %0d expected 2", idx1); end
    compared++; if (busy1 !== 1'b0) begin mismatched++; $display("FAIL basic_busy_end: got %b expected 0", busy1); end
  endtask

  task automatic test_mismatch();
    int cyc;
    int exp_cyc;
    logic [AW-1:0] exp_idx;
`ifdef DP_SEQ_STOP_ON_FAIL_EN
    exp_cyc = 5; exp_idx = 4'd1;
`else
    exp_cyc = 7; exp_idx = 4'd2;
`endif
    load_vec(1, -2, 5, 4);
    start_run(3, cyc);
    wait_done(1'b0, cyc);
    compared++; if (cyc !== exp_cyc) begin mismatched++; $display("FAIL miss_cycles: got %0d expected %0d", cyc, exp_cyc); end
    compared++; if (mis1 !== 5'd1) begin mismatched++; $display("FAIL miss_cnt: got %0d expected 1", mis1); end
    compared++; if (pass1 !== 1'b0) begin mismatched++; $display("FAIL miss_pass: got %b expected 0", pass1); end
    compared++; if (idx1 !== exp_idx) begin mismatched++; $display("FAIL miss_idx: got %0d expected %0d", idx1, exp_idx); end
    load_vec(1, -2, 5, 3);
  endtask

  task automatic test_busy_ignore();
    int cyc;
    start_run(3, cyc);
    @(negedge clk); cyc++;
    start = 1'b1; load_we = 1'b1; load_addr = 4'd0; load_a = 8'd99; load_b = 8'd99; load_exp = 16'd0;
    @(negedge clk); cyc++;
    start = 1'b0; load_we = 1'b0;
    compared++; if (idx1 !== 4'd1 || busy1 !== 1'b1) begin
      mismatched++; $display("FAIL busy_mid: got idx %0d busy %b expected idx 1 busy 1", idx1, busy1);
    end
    wait_done(1'b0, cyc);
    compared++; if (cyc !== 7) begin mismatched++; $display("FAIL busy_cycles: got %0d expected 7", cyc); end
    compared++; if (pass1 !== 1'b1) begin mismatched++; $display("FAIL busy_pass: got %b expected 1", pass1); end
    start_run(1, cyc);
    compared++; if (dp1.op_a !== 8'd3 || dp1.op_b !== 8'd4) begin
      mismatched++; $display("FAIL busy_mem: got %0d,%0d expected 3,4", dp1.op_a, dp1.op_b);
    end
    wait_done(1'b0, cyc);
    compared++; if (cyc !== 3 || pass1 !== 1'b1) begin
      mismatched++; $display("FAIL busy_rerun: got cycles %0d pass %b expected 3 and 1", cyc, pass1);
    end
  endtask

  task automatic test_load_and_start();
    int cyc;
    @(negedge clk);
    load_we = 1'b1; load_addr = 4'd0; load_a = 8'd10; load_b = 8'd20; load_exp = 16'd30;
    vec_count = 5'd1; start = 1'b1;
    @(negedge clk);
    load_we = 1'b0; start = 1'b0; cyc = 1;
    compared++; if (dp1.op_a !== 8'd10 || dp1.op_b !== 8'd20) begin
      mismatched++; $display("FAIL ldst_ops: got %0d,%0d expected 10,20", dp1.op_a, dp1.op_b);
    end
    wait_done(1'b0, cyc);
    compared++; if (cyc !== 3 || pass1 !== 1'b1) begin
      mismatched++; $display("FAIL ldst_done: got cycles %0d pass %b expected 3 and 1", cyc, pass1);
    end
  endtask

  task automatic test_lat3_reset();
    int cyc;
    @(negedge clk); rst = 1'b0;
    @(negedge clk); rst = 1'b1;
    load_vec(0, 3, 4, 7);
    load_vec(1, -2, 5, 3);
    load_vec(2, 127, 1, 128);
    start_run(3, cyc);
    repeat (5) begin @(negedge clk); cyc++; end
    compared++; if (busy3 !== 1'b1 || idx3 !== 4'd1 || dp3.op_a !== 8'hFE) begin
      mismatched++; $display("FAIL lat3_mid: got busy %b idx %0d op_a %0d expected 1, 1, -2", busy3, idx3, dp3.op_a);
    end
    #2 rst = 1'b0;
    #1;
    compared++; if (dp3.op_a !== 8'h00 || dp3.op_b !== 8'h00) begin
      mismatched++; $display("FAIL lat3_rst_ops: got %0d,%0d expected 0,0", dp3.op_a, dp3.op_b);
    end
    compared++; if (busy3 !== 1'b0 || done3 !== 1'b0 || pass3 !== 1'b0) begin
      mismatched++; $display("FAIL lat3_rst_flags: got busy %b done %b pass %b expected 0,0,0", busy3, done3, pass3);
    end
    compared++; if (idx3 !== 4'd0 || mis3 !== 5'd0) begin
      mismatched++; $display("FAIL lat3_rst_cnt: got idx %0d mis %0d expected 0,0", idx3, mis3);
    end
    @(negedge clk); rst = 1'b1;
    start_run(3, cyc);
    compared++; if (idx3 !== 4'd0 || dp3.op_a !== 8'd3 || busy3 !== 1'b1) begin
      mismatched++; $display("FAIL lat3_restart: got idx %0d op_a %0d busy %b expected 0, 3, 1", idx3, dp3.op_a, busy3);
    end
    wait_done(1'b1, cyc);
    compared++; if (cyc !== 13) begin mismatched++; $display("FAIL lat3_cycles: got %0d expected 13", cyc); end
    compared++; if (pass3 !== 1'b1 || mis3 !== 5'd0 || idx3 !== 4'd2) begin
      mismatched++; $display("FAIL lat3_result: got pass %b mis %0d idx %0d expected 1, 0, 2", pass3, mis3, idx3);
    end
  endtask

  task automatic test_depth();
    int cyc;
    int exp_cyc;
    logic [CW-1:0] exp_mis;
    logic [AW-1:0] exp_idx;
`ifdef DP_SEQ_STOP_ON_FAIL_EN
    exp_cyc = 3; exp_mis = 5'd1; exp_idx = 4'd0;
`else
    exp_cyc = 33; exp_mis = 5'd16; exp_idx = 4'd15;
`endif
    for (int i = 0; i < DEPTH; i++) load_vec(i, i, 1, 0);
    start_run(17, cyc);
    wait_done(1'b0, cyc);
    compared++; if (cyc !== exp_cyc) begin mismatched++; $display("FAIL depth_cycles: got %0d expected %0d", cyc, exp_cyc); end
    compared++; if (mis1 !== exp_mis) begin mismatched++; $display("FAIL depth_mis: got %0d expected %0d", mis1, exp_mis); end
    compared++; if (idx1 !== exp_idx) begin mismatched++; $display("FAIL depth_idx: got %0d expected %0d", idx1, exp_idx); end
    compared++; if (pass1 !== 1'b0) begin mismatched++; $display("FAIL depth_pass: got %b expected 0", pass1); end
  endtask

  initial begin
    test_reset();
    test_zero_count();
    test_basic();
    test_mismatch();
    test_busy_ignore();
    test_load_and_start();
    test_lat3_reset();
    test_depth();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
